// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Byte-addressed data memory behind a valid/ready request/response handshake.
//   One request is outstanding at a time. An accepted request waits
//   WAIT_CYCLES wait states, then the access is performed on the edge that
//   enters RESP. The response is held until the initiator takes it.
//   Storage is big-endian for halfwords. Out-of-range accesses complete with
//   rsp_err=1, perform no write and return zero data. Addresses never wrap.
//
//   Optional feature (compile-time macro):
//     MISALIGN_CHECK_EN - when defined, a halfword request with an odd
//                         address is rejected with rsp_err=1.
//
//   Parameters:
//     DEPTH       - storage size in bytes (>= 2)
//     WAIT_CYCLES - wait states between acceptance and response (0..15)
//
//   Ports:
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset (memory is not reset)
//     req_valid  in   request present
//     req_ready  out  responder idle and able to accept
//     req_write  in   1 = store, 0 = load
//     req_half   in   1 = halfword, 0 = byte
//     req_addr   in   byte address [15:0]
//     req_wdata  in   store data [15:0] (byte store uses [7:0])
//     rsp_valid  out  response available
//     rsp_ready  in   initiator consumes the response
//     rsp_rdata  out  load data [15:0] (zero for stores and errors)
//     rsp_err    out  access rejected
// -----------------------------------------------------------------------------
module data_mem_resp #(
   parameter int DEPTH       = 72,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_half,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);
   localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [3:0]    cnt_r;
   logic [3:0]    cnt_s;
   logic          accept_s;
   logic          enter_resp_s;

   logic          cap_write_r;
   logic          cap_half_r;
   logic [15:0]   cap_addr_r;
   logic [15:0]   cap_wdata_r;

   logic          acc_write_s;
   logic          acc_half_s;
   logic [15:0]   acc_addr_s;
   logic [15:0]   acc_wdata_s;
   logic [16:0]   acc_addr_p1_s;
   logic          in_range_s;
   logic          acc_err_s;
   logic          mem_we_s;
   logic [AW-1:0] idx0_s;
   logic [AW-1:0] idx1_s;
   logic [15:0]   rdata_s;

   logic [7:0]    mem_r [DEPTH];

   logic          req_ready_r;
   logic          rsp_valid_r;
   logic [15:0]   rsp_rdata_r;
   logic          rsp_err_r;

   // State and wait-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic, acceptance and RESP-entry strobes
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      accept_s     = 1'b0;
      enter_resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               accept_s = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_s      = ST_RESP;
                  enter_resp_s = 1'b1;
                  cnt_s        = 4'd0;
               end else begin
                  state_s = ST_WAIT;
                  cnt_s   = WAIT_W;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // The edge that takes the counter to zero is the edge entering
            // RESP; a counter already at zero is treated the same way.
            if (cnt_r <= 4'd1) begin
               cnt_s        = 4'd0;
               state_s      = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_s   = cnt_r - 4'd1;
               state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            // Returning to IDLE does not accept a request on the same edge.
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // Captured copy of the request fields, taken on the accepting edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_write_r <= 1'b0;
         cap_half_r  <= 1'b0;
         cap_addr_r  <= 16'h0000;
         cap_wdata_r <= 16'h0000;
      end else if (accept_s) begin
         cap_write_r <= req_write;
         cap_half_r  <= req_half;
         cap_addr_r  <= req_addr;
         cap_wdata_r <= req_wdata;
      end
   end

   // Access operands, range/alignment check and read data for the RESP entry
   always_comb begin
      // With no wait states the access happens on the accepting edge, so the
      // operands come straight from the request port.
      if (WAIT_CYCLES == 0) begin
         acc_write_s = req_write;
         acc_half_s  = req_half;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
      end else begin
         acc_write_s = cap_write_r;
         acc_half_s  = cap_half_r;
         acc_addr_s  = cap_addr_r;
         acc_wdata_s = cap_wdata_r;
      end

      // 17-bit arithmetic so that a+1 never wraps back into range.
      acc_addr_p1_s = {1'b0, acc_addr_s} + 17'd1;
      in_range_s    = ({1'b0, acc_addr_s} < DEPTH_W) &&
                      (!acc_half_s || (acc_addr_p1_s < DEPTH_W));
`ifdef MISALIGN_CHECK_EN
      acc_err_s     = !in_range_s || (acc_half_s && acc_addr_s[0]);
`else
      acc_err_s     = !in_range_s;
`endif
      idx0_s   = acc_addr_s[AW-1:0];
      idx1_s   = acc_addr_p1_s[AW-1:0];
      mem_we_s = enter_resp_s && acc_write_s && !acc_err_s && rst_n;

      if (acc_err_s || acc_write_s) begin
         rdata_s = 16'h0000;
      end else if (acc_half_s) begin
         rdata_s = {mem_r[idx0_s], mem_r[idx1_s]};
      end else begin
         rdata_s = {8'h00, mem_r[idx0_s]};
      end
   end

   // Storage array, big-endian halfword writes; deliberately not reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         if (acc_half_s) begin
            mem_r[idx0_s] <= acc_wdata_s[15:8];
            mem_r[idx1_s] <= acc_wdata_s[7:0];
         end else begin
            mem_r[idx0_s] <= acc_wdata_s[7:0];
         end
      end
   end

   // Registered handshake flags and response payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 16'h0000;
         rsp_err_r   <= 1'b0;
      end else begin
         req_ready_r <= (state_s == ST_IDLE);
         rsp_valid_r <= (state_s == ST_RESP);
         if (enter_resp_s) begin
            rsp_rdata_r <= rdata_s;
            rsp_err_r   <= acc_err_s;
         end else if (accept_s) begin
            rsp_rdata_r <= 16'h0000;
            rsp_err_r   <= 1'b0;
         end
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
//   Self-checking bench for data_mem_resp (DEPTH=72, WAIT_CYCLES=2). A byte
//   array reference model computes expected load data and error flags from
//   the address/size rules; directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

   localparam int DEPTH = 72;
   localparam int WC    = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_half;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mdl [DEPTH];

   data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_half  (req_half),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: applies one access, returns the expected response
   task automatic model_access(input bit w, input bit h, input int a, input logic [15:0] wd,
                               output logic err, output logic [15:0] rd);
      int last;
      last = h ? a + 1 : a;
      err  = (last >= DEPTH);
`ifdef MISALIGN_CHECK_EN
      if (h && (a % 2 == 1)) err = 1'b1;
`endif
      rd = 16'h0000;
      if (!err) begin
         if (w) begin
            if (h) begin
               mdl[a]   = wd[15:8];
               mdl[a+1] = wd[7:0];
            end else begin
               mdl[a] = wd[7:0];
            end
         end else begin
            rd = h ? {mdl[a], mdl[a+1]} : {8'h00, mdl[a]};
         end
      end
   endtask

   // Presents a request at a negedge while idle; returns at the negedge after acceptance
   task automatic start_req(input bit w, input bit h, input logic [15:0] a, input logic [15:0] wd,
                            input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = w;
      req_half  = h;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits at negedges for rsp_valid; k counts edges including the accepting one
   task automatic wait_rsp(input string tag, output int k);
      k = 1;
      while (!rsp_valid && k < 40) begin
         chk({tag, "_wait_ready"}, {31'd0, req_ready}, 32'd0);
         if (k == 1) chk({tag, "_err_clr"}, {31'd0, rsp_err}, 32'd0);
         @(negedge clk);
         k++;
      end
   endtask

   // Full transaction with optional response hold and ignored request poke
   task automatic do_req(input bit w, input bit h, input logic [15:0] a, input logic [15:0] wd,
                         input int hold, input bit poke, input string tag,
                         output logic [15:0] rd_o, output logic err_o);
      logic        exp_err;
      logic [15:0] exp_rd;
      int          k;
      start_req(w, h, a, wd, tag);
      model_access(w, h, int'(a), wd, exp_err, exp_rd);
      wait_rsp(tag, k);
      chk({tag, "_latency"}, k, WC + 1);
      rd_o  = rsp_rdata;
      err_o = rsp_err;
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 1) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_half  = 1'b1;
            req_addr  = 16'd0;
            req_wdata = 16'hDEAD;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({tag, "_hold_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
         chk({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
         chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   // Asserts reset between edges and checks the immediate output values
   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rst_rdata"}, {16'd0, rsp_rdata}, 32'd0);
      chk({tag, "_rst_err"}, {31'd0, rsp_err}, 32'd0);
      chk({tag, "_rst_ready"}, {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < WC + 3; i++) begin
         @(negedge clk);
         chk({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
      end
   endtask

   initial begin
      logic [15:0] rd;
      logic        er;
      logic        w;
      logic        h;
      logic [15:0] a;
      int          k;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_half  = 1'b0;
      req_addr  = 16'd0;
      req_wdata = 16'd0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
      chk("reset_err", {31'd0, rsp_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", {31'd0, req_ready}, 32'd1);

      // Fill every byte so the model and the array agree
      for (int i = 0; i < DEPTH; i++)
         do_req(1'b1, 1'b0, 16'(i), 16'($urandom), 0, 1'b0, "init", rd, er);

      // Big-endian halfword store/load and byte accesses
      do_req(1'b1, 1'b1, 16'd4, 16'hBEEF, 0, 1'b0, "st_beef", rd, er);
      chk("st_beef_rd0", {16'd0, rd}, 32'd0);
      do_req(1'b0, 1'b1, 16'd4, 16'h0000, 0, 1'b0, "ld_beef", rd, er);
      chk("ld_beef_const", {16'd0, rd}, 32'h0000BEEF);
      chk("ld_beef_err", {31'd0, er}, 32'd0);
      do_req(1'b0, 1'b0, 16'd5, 16'h0000, 0, 1'b0, "ld_b5", rd, er);
      chk("ld_b5_const", {16'd0, rd}, 32'h000000EF);
      do_req(1'b1, 1'b0, 16'd4, 16'hFF12, 0, 1'b0, "st_b4", rd, er);
      do_req(1'b0, 1'b1, 16'd4, 16'h0000, 0, 1'b0, "ld_12ef", rd, er);
      chk("ld_12ef_const", {16'd0, rd}, 32'h000012EF);

      // Range boundaries, no wrap-around
      do_req(1'b0, 1'b0, 16'd72, 16'h0000, 0, 1'b0, "ld_b72", rd, er);
      chk("ld_b72_errc", {31'd0, er}, 32'd1);
      do_req(1'b0, 1'b1, 16'd72, 16'h0000, 0, 1'b0, "ld_h72", rd, er);
      do_req(1'b1, 1'b1, 16'd71, 16'h5A5A, 0, 1'b0, "st_h71", rd, er);
      chk("st_h71_errc", {31'd0, er}, 32'd1);
      do_req(1'b0, 1'b0, 16'd71, 16'h0000, 0, 1'b0, "ld_b71", rd, er);
      do_req(1'b0, 1'b1, 16'd70, 16'h0000, 0, 1'b0, "ld_h70", rd, er);
      do_req(1'b1, 1'b1, 16'hFFFF, 16'h1111, 0, 1'b0, "st_hffff", rd, er);
      do_req(1'b0, 1'b1, 16'd0, 16'h0000, 0, 1'b0, "ld_h0", rd, er);

      // Response held five cycles with an ignored request in the window
      do_req(1'b0, 1'b1, 16'd4, 16'h0000, 5, 1'b1, "hold", rd, er);
      do_req(1'b0, 1'b1, 16'd0, 16'h0000, 0, 1'b0, "poke_ignored", rd, er);

      // Reset during WAIT aborts a pending store
      do_req(1'b1, 1'b1, 16'd8, 16'h5566, 0, 1'b0, "st_5566", rd, er);
      start_req(1'b1, 1'b1, 16'd8, 16'hAAAA, "st_aaaa");
      reset_pulse("wait_rst");
      do_req(1'b0, 1'b1, 16'd8, 16'h0000, 0, 1'b0, "ld_after_abort", rd, er);
      chk("ld_after_abort_const", {16'd0, rd}, 32'h00005566);

      // Reset during RESP keeps a committed store, drops a pending response
      start_req(1'b1, 1'b1, 16'd10, 16'h1357, "st_1357");
      model_access(1'b1, 1'b1, 10, 16'h1357, er, rd);
      wait_rsp("st_1357", k);
      chk("st_1357_latency", k, WC + 1);
      reset_pulse("resp_rst_st");
      start_req(1'b0, 1'b1, 16'd4, 16'h0000, "ld_rst");
      wait_rsp("ld_rst", k);
      chk("ld_rst_rdata", {16'd0, rsp_rdata}, 32'h000012EF);
      reset_pulse("resp_rst_ld");
      do_req(1'b0, 1'b1, 16'd10, 16'h0000, 0, 1'b0, "ld_1357", rd, er);
      chk("ld_1357_const", {16'd0, rd}, 32'h00001357);

      // Odd-address halfword load
      do_req(1'b0, 1'b1, 16'd3, 16'h0000, 0, 1'b0, "ld_h3", rd, er);
`ifdef MISALIGN_CHECK_EN
      chk("ld_h3_misalign_err", {31'd0, er}, 32'd1);
      chk("ld_h3_misalign_rd", {16'd0, rd}, 32'd0);
`else
      chk("ld_h3_err", {31'd0, er}, 32'd0);
      chk("ld_h3_rd", {16'd0, rd}, {16'd0, mdl[3], mdl[4]});
`endif

      // Random traffic against the model
      for (int n = 0; n < 200; n++) begin
         w = 1'($urandom);
         h = 1'($urandom);
         if ($urandom_range(0, 7) == 0) a = 16'($urandom);
         else                           a = 16'($urandom_range(0, DEPTH + 2));
         do_req(w, h, a, 16'($urandom), $urandom_range(0, 3), 1'b0, "rand", rd, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
